// File: rtl/leitura_pkg.sv
// Shared state encoding, glyph table and defaults for leitura_segmentos.
// Hex glyphs A..F are decoded only when LEITURA_HEX_EN is defined.
package leitura_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OFFER = 2'd2,
    LOCK  = 2'd3
  } state_e;

  localparam int unsigned STABLE_CYCLES_DEF = 4;

  // Segment words are ordered abcdefg, a in the MSB.
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

endpackage

// File: rtl/seg_para_codigo.sv
// Combinational seven-segment to 4-bit code lookup.
// Letters A..F are legal only when LEITURA_HEX_EN is defined.
module seg_para_codigo
  import leitura_pkg::*;
(
  input  logic [6:0] iSeg,
  output logic [3:0] oCode,
  output logic       oErr
);

  always_comb begin
    oCode = 4'h0;
    oErr  = 1'b0;
    case (iSeg)
      GLYPH_0: oCode = 4'h0;
      GLYPH_1: oCode = 4'h1;
      GLYPH_2: oCode = 4'h2;
      GLYPH_3: oCode = 4'h3;
      GLYPH_4: oCode = 4'h4;
      GLYPH_5: oCode = 4'h5;
      GLYPH_6: oCode = 4'h6;
      GLYPH_7: oCode = 4'h7;
      GLYPH_8: oCode = 4'h8;
      GLYPH_9: oCode = 4'h9;
`ifdef LEITURA_HEX_EN
      GLYPH_A: oCode = 4'hA;
      GLYPH_B: oCode = 4'hB;
      GLYPH_C: oCode = 4'hC;
      GLYPH_D: oCode = 4'hD;
      GLYPH_E: oCode = 4'hE;
      GLYPH_F: oCode = 4'hF;
`endif
      default: oErr = 1'b1;
    endcase
  end

endmodule

// File: rtl/leitura_segmentos.sv
// Debounced seven-segment reader offering one code per stable glyph.
// Define LEITURA_HEX_EN to also accept the letters A..F.
module leitura_segmentos
  import leitura_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iA,
  input  logic iB,
  input  logic iC,
  input  logic iD,
  input  logic iE,
  input  logic iF,
  input  logic iG,
  input  logic iReady,
  output logic oW,
  output logic oX,
  output logic oY,
  output logic oZ,
  output logic oValid,
  output logic oErr
);

  localparam logic [7:0] LIMIT = 8'(STABLE_CYCLES);

  logic [6:0] seg;
  assign seg = {iA, iB, iC, iD, iE, iF, iG};

  state_e     state_q, state_d;
  logic [6:0] sample_q, sample_d;
  logic [7:0] count_q, count_d;
  logic [3:0] code_q, code_d;
  logic       err_q, err_d;
  logic       cap;

  logic [3:0] dec_code;
  logic       dec_err;

  seg_para_codigo u_dec (
    .iSeg  (seg),
    .oCode (dec_code),
    .oErr  (dec_err)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    count_d  = count_q;
    code_d   = code_q;
    err_d    = err_q;
    cap      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seg != 7'd0) cap = 1'b1;
      end
      COUNT: begin
        if (seg == sample_q) begin
          count_d = count_q + 8'd1;
          if (count_d == LIMIT) begin
            state_d = OFFER;
            code_d  = dec_code;
            err_d   = dec_err;
          end
        end else if (seg == 7'd0) begin
          state_d = IDLE;
          count_d = 8'd0;
        end else begin
          cap = 1'b1;
        end
      end
      OFFER: begin
        if (iReady) state_d = LOCK;
      end
      LOCK: begin
        if (seg == 7'd0) begin
          state_d = IDLE;
          count_d = 8'd0;
        end else if (seg != sample_q) begin
          cap = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh word is its own first stable sample.
    if (cap) begin
      sample_d = seg;
      count_d  = 8'd1;
      if (LIMIT == 8'd1) begin
        state_d = OFFER;
        code_d  = dec_code;
        err_d   = dec_err;
      end else begin
        state_d = COUNT;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      sample_q <= 7'd0;
      count_q  <= 8'd0;
      code_q   <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      count_q  <= count_d;
      code_q   <= code_d;
      err_q    <= err_d;
    end
  end

  assign {oW, oX, oY, oZ} = code_q;
  assign oValid = (state_q == OFFER);
  assign oErr   = err_q;

endmodule

// File: tb/tb_leitura_segmentos.sv
// Randomized and directed bench for leitura_segmentos against a run-length model.
// Honours LEITURA_HEX_EN for the expected glyph set.
module tb_leitura_segmentos;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] seg, seg1;
  logic rdy, rdy1;
  logic w, x, y, z, valid, err;
  logic w1, x1, y1, z1, valid1, err1;
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leitura_segmentos #(.STABLE_CYCLES(S)) dut (
    .iClk(clk), .iRstN(rst_n),
    .iA(seg[6]), .iB(seg[5]), .iC(seg[4]), .iD(seg[3]),
    .iE(seg[2]), .iF(seg[1]), .iG(seg[0]),
    .iReady(rdy),
    .oW(w), .oX(x), .oY(y), .oZ(z),
    .oValid(valid), .oErr(err)
  );

  leitura_segmentos #(.STABLE_CYCLES(1)) dut1 (
    .iClk(clk), .iRstN(rst_n),
    .iA(seg1[6]), .iB(seg1[5]), .iC(seg1[4]), .iD(seg1[3]),
    .iE(seg1[2]), .iF(seg1[1]), .iG(seg1[0]),
    .iReady(rdy1),
    .oW(w1), .oX(x1), .oY(y1), .oZ(z1),
    .oValid(valid1), .oErr(err1)
  );

  bit [6:0] gl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

`ifdef LEITURA_HEX_EN
  localparam int NLEGAL = 16;
`else
  localparam int NLEGAL = 10;
`endif

  // Returns {err, code}.
  function automatic logic [4:0] look(input logic [6:0] wd);
    for (int i = 0; i < NLEGAL; i++)
      if (gl[i] == wd) return {1'b0, 4'(i)};
    return 5'b1_0000;
  endfunction

  // Model: offer once a word has been seen S edges in a row, then
  // suppress that word until the input changes.
  bit m_off, m_err, m_lock;
  bit [3:0] m_code;
  bit [6:0] m_runw, m_lockw;
  int m_runlen;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_off = 0; m_code = 0; m_err = 0;
      m_lock = 0; m_runlen = 0;
    end else if (m_off) begin
      if (rdy) begin m_off = 0; m_lock = 1; end
    end else if (seg == 7'd0) begin
      m_runlen = 0; m_lock = 0;
    end else if (!(m_lock && seg == m_lockw)) begin
      if (m_runlen > 0 && seg == m_runw) m_runlen++;
      else begin m_runw = seg; m_runlen = 1; end
      m_lock = 0;
      if (m_runlen == S) begin
        m_off = 1;
        {m_err, m_code} = look(seg);
        m_lockw = seg;
        m_runlen = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      checks++;
      if ({valid, w, x, y, z, err} != {m_off, m_code, m_err}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got v=%b c=%b e=%b want v=%b c=%b e=%b",
          $time, valid, {w, x, y, z}, err, m_off, m_code, m_err);
      end
    end
  end

  function automatic logic [5:0] obs();
    return {valid, w, x, y, z, err};
  endfunction

  function automatic logic [5:0] obs1();
    return {valid1, w1, x1, y1, z1, err1};
  endfunction

  task automatic chk(input string n, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", n, act, exp);
    end
  endtask

  task automatic cyc(input logic [6:0] wd, input logic r, input logic rn);
    seg = wd; rdy = r; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; seg = 7'd0; rdy = 1'b0; seg1 = 7'd0; rdy1 = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    chk("reset", obs(), 6'b0);
    chk("reset_s1", obs1(), 6'b0);
    cyc(7'd0, 0, 1);

    seg1 = 7'b0110011;
    cyc(7'd0, 0, 1);
    chk("s1_offer", obs1(), 6'b1_0100_0);
    seg1 = 7'd0; rdy1 = 1'b1;
    cyc(7'd0, 0, 1);
    chk("s1_ack", {5'd0, valid1}, 6'd0);
    rdy1 = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      cyc(7'b1011011, 1, 1);
      if (i < 4) chk("g5_wait", {5'd0, valid}, 6'd0);
    end
    chk("g5_offer", obs(), 6'b1_0101_0);
    cyc(7'b1011011, 1, 1);
    chk("g5_drop", {5'd0, valid}, 6'd0);

    for (int i = 1; i <= 7; i++) begin
      cyc(i <= 3 ? 7'b1111110 : 7'b0110000, 0, 1);
      if (i < 7) chk("g0_never", {5'd0, valid}, 6'd0);
    end
    chk("g1_offer", obs(), 6'b1_0001_0);
    cyc(7'b0110000, 1, 1);

    for (int i = 1; i <= 20; i++) begin
      cyc(i >= 10 ? 7'b0110000 : 7'b1111111, 0, 1);
      if (i >= 4) chk("g8_hold", obs(), 6'b1_1000_0);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc(7'b1111111, 1, 1);
      chk("g8_once", {5'd0, valid}, 6'd0);
    end

    for (int i = 1; i <= 4; i++) cyc(7'b0110000, 0, 1);
    chk("pre_rst", {5'd0, valid}, 6'd1);
    cyc(7'b0110000, 0, 0);
    chk("rst_offer", obs(), 6'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(7'b0110000, 0, 1);
      chk("post_rst", {5'd0, valid}, i == 4 ? 6'd1 : 6'd0);
    end
    cyc(7'b0110000, 1, 1);

    for (int i = 1; i <= 4; i++) cyc(7'b1110111, 0, 1);
`ifdef LEITURA_HEX_EN
    chk("hexA", obs(), 6'b1_1010_0);
`else
    chk("hexA", obs(), 6'b1_0000_1);
`endif
    cyc(7'b1110111, 1, 1);
    for (int i = 1; i <= 4; i++) cyc(7'b1000001, 0, 1);
    chk("illegal", obs(), 6'b1_0000_1);
    cyc(7'b1000001, 1, 1);

    for (int k = 0; k < 80; k++) begin
      logic [6:0] wd;
      int sel, len;
      sel = $urandom_range(0, 9);
      if (sel < 2) wd = 7'd0;
      else if (sel < 8) wd = gl[$urandom_range(0, 15)];
      else wd = 7'($urandom);
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++)
        cyc(wd, $urandom_range(0, 3) == 0, $urandom_range(0, 60) != 0);
    end

    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
